i8255_bus_master: RTL and testbench

I8255_BUS_MASTER -- requirements
Module: i8255_bus_master

---
 rtl/i8255_bus_master_if.sv | 31 +++
 rtl/i8255_bus_master.sv | 198 +++++++++++++++++++
 tb/tb_i8255_bus_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i8255_bus_master_if.sv
// Host request/response and 8255-style peripheral bus bundle.
// master: the bus master block; slave: host plus peripheral side.
interface i8255_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_we;
  logic [7:0] rsp_rdata;
  logic       cs;
  logic       rd;
  logic       wr;
  logic [1:0] a;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, d_in,
    output req_ready, rsp_valid, rsp_we, rsp_rdata,
    output cs, rd, wr, a, d_out, d_oe
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, d_in,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata,
    input  cs, rd, wr, a, d_out, d_oe
  );
endinterface

// File: rtl/i8255_bus_master.sv
// Sequences host requests into SETUP/STROBE/HOLD cycles on an 8255 bus.
// Define I8255_BM_SKID_EN for a one-entry request buffer.
module i8255_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic clk,
  input  logic reset,
  i8255_bus_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cs_q, cs_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [1:0] a_q, a_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       we_q, we_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_we_q, rsp_we_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;

  logic       ready;
  logic       launch;
  logic       l_we;
  logic [1:0] l_addr;
  logic [7:0] l_wdata;

`ifdef I8255_BM_SKID_EN
  logic       accept;
  logic       sb_vld_q, sb_vld_d;
  logic       sb_we_q, sb_we_d;
  logic [1:0] sb_addr_q, sb_addr_d;
  logic [7:0] sb_wdata_q, sb_wdata_d;

  // A buffered request always wins over the live input.
  always_comb begin
    ready      = !sb_vld_q && !reset;
    accept     = bus.req_valid && ready;
    launch     = (state_q == IDLE) && (sb_vld_q || accept);
    l_we       = sb_vld_q ? sb_we_q    : bus.req_we;
    l_addr     = sb_vld_q ? sb_addr_q  : bus.req_addr;
    l_wdata    = sb_vld_q ? sb_wdata_q : bus.req_wdata;
    sb_vld_d   = sb_vld_q;
    sb_we_d    = sb_we_q;
    sb_addr_d  = sb_addr_q;
    sb_wdata_d = sb_wdata_q;
    if (state_q == IDLE) begin
      sb_vld_d = 1'b0;
    end else if (accept) begin
      sb_vld_d   = 1'b1;
      sb_we_d    = bus.req_we;
      sb_addr_d  = bus.req_addr;
      sb_wdata_d = bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_vld_q   <= 1'b0;
      sb_we_q    <= 1'b0;
      sb_addr_q  <= 2'b00;
      sb_wdata_q <= 8'h00;
    end else begin
      sb_vld_q   <= sb_vld_d;
      sb_we_q    <= sb_we_d;
      sb_addr_q  <= sb_addr_d;
      sb_wdata_q <= sb_wdata_d;
    end
  end
`else
  always_comb begin
    ready   = (state_q == IDLE) && !reset;
    launch  = bus.req_valid && ready;
    l_we    = bus.req_we;
    l_addr  = bus.req_addr;
    l_wdata = bus.req_wdata;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    a_d         = a_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    we_d        = we_q;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        cs_d = 1'b0;
        oe_d = 1'b0;
        if (launch) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          cs_d    = 1'b1;
          a_d     = l_addr;
          oe_d    = l_we;
          we_d    = l_we;
          if (l_we) dout_d = l_wdata;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
          rd_d    = !we_q;
          wr_d    = we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d     = HOLD;
          cnt_d       = HOLD_LD;
          rsp_rdata_d = we_q ? 8'h00 : bus.d_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
          rd_d  = !we_q;
          wr_d  = we_q;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d     = IDLE;
          cs_d        = 1'b0;
          oe_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      a_q         <= 2'b00;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      a_q         <= a_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.cs        = cs_q;
  assign bus.rd        = rd_q;
  assign bus.wr        = wr_q;
  assign bus.a         = a_q;
  assign bus.d_out     = dout_q;
  assign bus.d_oe      = oe_q;

endmodule

// File: tb/tb_i8255_bus_master.sv
// Bench for i8255_bus_master: directed scenarios plus random traffic
// checked against a timeline model of each transaction.
module tb_i8255_bus_master;
  localparam int S    = 1;
  localparam int T    = 2;
  localparam int H    = 1;
  localparam int N    = S + T + H;
  localparam int MAXE = 4096;

  logic clk = 1'b0;
  logic rst;
  i8255_bus_master_if bus ();

  always #5 clk = ~clk;

  i8255_bus_master #(
    .SETUP_CYC (S),
    .STROBE_CYC(T),
    .HOLD_CYC  (H)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  // Expected values for the period following each rising edge.
  bit         e_cs[MAXE];
  bit         e_rd[MAXE];
  bit         e_wr[MAXE];
  bit         e_oe[MAXE];
  bit         e_rsp[MAXE];
  bit         e_rspwe[MAXE];
  bit         e_ready[MAXE];
  logic [1:0] e_a[MAXE];
  logic [7:0] e_dout[MAXE];
  logic [7:0] din_at[MAXE];
  int         e_cap[MAXE];

  int         busy_rsp;
  bit         bfull;
  bit         b_we;
  logic [1:0] b_a;
  logic [7:0] b_d;
  bit         m_acc;

  int ecount = 0;
  int nvec   = 0;
  int nmis   = 0;
  bit chk_en = 1'b0;

  function automatic void launch_tx(int L, bit we, logic [1:0] ad,
                                    logic [7:0] wd);
    for (int j = L; j < L + N; j++) begin
      e_cs[j] = 1'b1;
      e_oe[j] = we;
    end
    for (int j = L + S; j < L + S + T; j++) begin
      if (we) e_wr[j] = 1'b1;
      else    e_rd[j] = 1'b1;
    end
    e_rsp[L+N]   = 1'b1;
    e_rspwe[L+N] = we;
    e_cap[L+N]   = L + S + T;
    for (int j = L; j < MAXE; j++) begin
      e_a[j] = ad;
      if (we) e_dout[j] = wd;
    end
    busy_rsp = L + N;
  endfunction

  task automatic step(bit r, bit v, bit we, logic [1:0] ad,
                      logic [7:0] wd, logic [7:0] di);
    int e;
    bit idle;
    bit rdy;
    e = ecount + 1;
    rst           = r;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = ad;
    bus.req_wdata = wd;
    bus.d_in      = di;
    din_at[e]     = di;
    m_acc         = 1'b0;
    if (r) begin
      rdy      = 1'b0;
      bfull    = 1'b0;
      busy_rsp = e;
      for (int j = e; j < MAXE; j++) begin
        e_cs[j]  = 1'b0;
        e_rd[j]  = 1'b0;
        e_wr[j]  = 1'b0;
        e_oe[j]  = 1'b0;
        e_rsp[j] = 1'b0;
        e_a[j]   = 2'b00;
        e_dout[j] = 8'h00;
      end
    end else begin
      idle = (e > busy_rsp);
`ifdef I8255_BM_SKID_EN
      rdy   = !bfull;
      m_acc = v && rdy;
      if (idle && bfull) begin
        launch_tx(e, b_we, b_a, b_d);
        bfull = 1'b0;
      end else if (idle && m_acc) begin
        launch_tx(e, we, ad, wd);
      end else if (m_acc) begin
        bfull = 1'b1;
        b_we  = we;
        b_a   = ad;
        b_d   = wd;
      end
`else
      rdy   = idle;
      m_acc = v && rdy;
      if (m_acc) launch_tx(e, we, ad, wd);
`endif
    end
    e_ready[e] = rdy;
    @(posedge clk);
    ecount = e;
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'($urandom));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      nvec++;
      if ({bus.cs, bus.rd, bus.wr, bus.d_oe, bus.rsp_valid, bus.a, bus.d_out}
          !== {e_cs[ecount], e_rd[ecount], e_wr[ecount], e_oe[ecount],
               e_rsp[ecount], e_a[ecount], e_dout[ecount]}) begin
        nmis++;
        $display("FAIL bus e=%0d got cs%b rd%b wr%b oe%b rv%b a%h d%h exp cs%b rd%b wr%b oe%b rv%b a%h d%h",
                 ecount, bus.cs, bus.rd, bus.wr, bus.d_oe, bus.rsp_valid,
                 bus.a, bus.d_out, e_cs[ecount], e_rd[ecount], e_wr[ecount],
                 e_oe[ecount], e_rsp[ecount], e_a[ecount], e_dout[ecount]);
      end
      nvec++;
      if (bus.req_ready !== e_ready[ecount+1]) begin
        nmis++;
        $display("FAIL ready e=%0d got=%b exp=%b", ecount, bus.req_ready,
                 e_ready[ecount+1]);
      end
      nvec++;
      if (bus.rd && bus.wr) begin
        nmis++;
        $display("FAIL rd_wr_overlap e=%0d got=11 exp=not both", ecount);
      end
      if (e_rsp[ecount]) begin
        nvec++;
        if ({bus.rsp_we, bus.rsp_rdata} !==
            {e_rspwe[ecount],
             e_rspwe[ecount] ? 8'h00 : din_at[e_cap[ecount]]}) begin
          nmis++;
          $display("FAIL rsp e=%0d got we%b %h exp we%b %h", ecount,
                   bus.rsp_we, bus.rsp_rdata, e_rspwe[ecount],
                   e_rspwe[ecount] ? 8'h00 : din_at[e_cap[ecount]]);
        end
      end
    end
  end

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 2'b11, 8'hFF, 8'h33);
    chk_en = 1'b1;
    repeat (3) step(1'b1, 1'b1, 1'b1, 2'b10, 8'($urandom), 8'($urandom));
    nvec++;
    if ({bus.cs, bus.rd, bus.wr, bus.d_oe, bus.a, bus.d_out,
         bus.rsp_valid, bus.rsp_we, bus.rsp_rdata, bus.req_ready} !== '0) begin
      nmis++;
      $display("FAIL reset_state got cs%b rd%b wr%b oe%b a%h d%h rv%b rdy%b exp all 0",
               bus.cs, bus.rd, bus.wr, bus.d_oe, bus.a, bus.d_out,
               bus.rsp_valid, bus.req_ready);
    end
    idle_step();
    nvec++;
    if (bus.req_ready !== 1'b1) begin
      nmis++;
      $display("FAIL reset_release_ready got=%b exp=1", bus.req_ready);
    end
  endtask

  task automatic test_write();
    idle_step();
    idle_step();
    step(1'b0, 1'b1, 1'b1, 2'd3, 8'h80, 8'h11);
    for (int c = 1; c <= 6; c++) begin
      nvec++;
      if ({bus.cs, bus.wr, bus.rd, bus.d_oe, bus.rsp_valid} !==
          {c <= 4, c == 2 || c == 3, 1'b0, c <= 4, c == 5}) begin
        nmis++;
        $display("FAIL write_cyc%0d got cs%b wr%b rd%b oe%b rv%b", c,
                 bus.cs, bus.wr, bus.rd, bus.d_oe, bus.rsp_valid);
      end
      if (c <= 4) begin
        nvec++;
        if ({bus.a, bus.d_out} !== {2'd3, 8'h80}) begin
          nmis++;
          $display("FAIL write_addr_data cyc%0d got a%h d%h exp a3 d80", c,
                   bus.a, bus.d_out);
        end
      end
      if (c == 5) begin
        nvec++;
        if ({bus.rsp_we, bus.rsp_rdata} !== {1'b1, 8'h00}) begin
          nmis++;
          $display("FAIL write_rsp got we%b %h exp we1 00", bus.rsp_we,
                   bus.rsp_rdata);
        end
      end
      step(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h22);
    end
  endtask

  task automatic test_read();
    idle_step();
    step(1'b0, 1'b1, 1'b0, 2'd1, 8'hC3, 8'hA5);
    for (int c = 1; c <= 6; c++) begin
      nvec++;
      if ({bus.cs, bus.rd, bus.wr, bus.d_oe, bus.rsp_valid} !==
          {c <= 4, c == 2 || c == 3, 1'b0, 1'b0, c == 5}) begin
        nmis++;
        $display("FAIL read_cyc%0d got cs%b rd%b wr%b oe%b rv%b", c,
                 bus.cs, bus.rd, bus.wr, bus.d_oe, bus.rsp_valid);
      end
      if (c == 5) begin
        nvec++;
        if ({bus.rsp_we, bus.rsp_rdata} !== {1'b0, 8'h5A}) begin
          nmis++;
          $display("FAIL read_rsp got we%b %h exp we0 5a", bus.rsp_we,
                   bus.rsp_rdata);
        end
      end
      step(1'b0, 1'b0, 1'b0, 2'b00, 8'h00,
           (c == 2 || c == 3) ? 8'h5A : 8'hA5);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int nacc;
    int rsps[$];
    bit gap_cs;
    idle_step();
    idle_step();
    nacc = 0;
    k = -1;
    gap_cs = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (nacc < 2) step(1'b0, 1'b1, 1'b1, 2'(i), 8'(i + 8'h40), 8'h00);
      else idle_step();
      if (m_acc) begin
        if (nacc == 0) k = ecount;
        nacc++;
      end
      if (bus.rsp_valid) rsps.push_back(ecount);
      if (k >= 0 && ecount == k + N) gap_cs = bus.cs;
    end
    nvec++;
    if (rsps.size() != 2 || rsps[0] != k + N || rsps[1] != k + 2 * N + 1) begin
      nmis++;
      $display("FAIL b2b_rsp_times got n=%0d first=%0d exp %0d,%0d",
               rsps.size(), rsps.size() > 0 ? rsps[0] - k : -1, N,
               2 * N + 1);
    end
    nvec++;
    if (gap_cs !== 1'b0) begin
      nmis++;
      $display("FAIL b2b_gap got cs=%b exp=0", gap_cs);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_rsp;
    idle_step();
    step(1'b0, 1'b1, 1'b1, 2'd2, 8'h99, 8'h00);
    idle_step();
    nvec++;
    if (bus.wr !== 1'b1) begin
      nmis++;
      $display("FAIL rmid_strobe got wr=%b exp=1", bus.wr);
    end
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    nvec++;
    if ({bus.cs, bus.wr, bus.d_oe, bus.rsp_valid, bus.req_ready} !== 5'b0) begin
      nmis++;
      $display("FAIL rmid_abort got cs%b wr%b oe%b rv%b rdy%b exp 0",
               bus.cs, bus.wr, bus.d_oe, bus.rsp_valid, bus.req_ready);
    end
    idle_step();
    nvec++;
    if (bus.req_ready !== 1'b1) begin
      nmis++;
      $display("FAIL rmid_ready got=%b exp=1", bus.req_ready);
    end
    seen_rsp = 1'b0;
    repeat (6) begin
      idle_step();
      seen_rsp |= bus.rsp_valid;
    end
    nvec++;
    if (seen_rsp !== 1'b0) begin
      nmis++;
      $display("FAIL rmid_no_rsp got=1 exp=0");
    end
  endtask

`ifdef I8255_BM_SKID_EN
  task automatic test_skid();
    int k;
    int guard;
    int rt[$];
    bit rw[$];
    idle_step();
    idle_step();
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'h01, 8'h00);
    k = ecount;
    idle_step();
    nvec++;
    if (bus.req_ready !== 1'b1) begin
      nmis++;
      $display("FAIL skid_ready_c2 got=%b exp=1", bus.req_ready);
    end
    step(1'b0, 1'b1, 1'b0, 2'd1, 8'h02, 8'h00);
    guard = 0;
    m_acc = 1'b0;
    while (!m_acc && guard < 10) begin
      nvec++;
      if (bus.req_ready !== (ecount >= k + N + 1)) begin
        nmis++;
        $display("FAIL skid_ready_full e=%0d got=%b exp=%b", ecount - k,
                 bus.req_ready, ecount >= k + N + 1);
      end
      if (bus.rsp_valid) begin
        rt.push_back(ecount);
        rw.push_back(bus.rsp_we);
      end
      step(1'b0, 1'b1, 1'b1, 2'd2, 8'h03, 8'h00);
      guard++;
    end
    repeat (12) begin
      if (bus.rsp_valid) begin
        rt.push_back(ecount);
        rw.push_back(bus.rsp_we);
      end
      idle_step();
    end
    nvec++;
    if (rt.size() != 3 || rt[0] != k + N || rt[1] != k + 2 * N + 1 ||
        rt[2] != k + 3 * N + 2 || rw[0] != 1'b1 || rw[1] != 1'b0 ||
        rw[2] != 1'b1) begin
      nmis++;
      $display("FAIL skid_order got n=%0d exp 3 rsps at %0d,%0d,%0d we 1,0,1",
               rt.size(), N, 2 * N + 1, 3 * N + 2);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 79) == 0, 1'($urandom), 1'($urandom),
           2'($urandom), 8'($urandom), 8'($urandom));
    end
    repeat (N + 2) idle_step();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 2'b00;
    bus.req_wdata = 8'h00;
    bus.d_in      = 8'h00;
    rst           = 1'b1;
    busy_rsp      = 0;
    bfull         = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
`ifdef I8255_BM_SKID_EN
    test_skid();
`endif
    test_random();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
